// File: rtl/avalon_mm_mult_host.sv
`timescale 1ns/1ps
// Avalon-MM host that runs one multiply job on the multiplier slave: write A, B, start, poll STATUS, read RES_LO/RES_HI.
// Latency: res_valid 9 edges after job accept when nothing stalls. Backpressure: commands hold under waitrequest; the result holds until res_ready.
module avalon_mm_mult_host #(
  parameter int SZ         = 32,
  parameter int ADDR_W     = 4,
  parameter int POLL_LIMIT = 1024
) (
  input  logic              clk,
  input  logic              _rst,
  input  logic              job_valid,
  output logic              job_ready,
  input  logic [SZ-1:0]     job_a,
  input  logic [SZ-1:0]     job_b,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [2*SZ-1:0]   res_data,
  output logic              res_timeout,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [SZ-1:0]     avm_writedata,
  input  logic [SZ-1:0]     avm_readdata,
  input  logic              avm_waitrequest,
  input  logic              avm_readdatavalid
);

  localparam int CW = $clog2(POLL_LIMIT + 1);
  localparam logic [CW-1:0] LAST_POLL = CW'(POLL_LIMIT - 1);

  localparam logic [ADDR_W-1:0] REG_A      = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] REG_B      = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] REG_CTRL   = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] REG_STATUS = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] REG_RES_LO = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] REG_RES_HI = ADDR_W'(5);

  typedef enum logic [3:0] {
    IDLE, WR_A, WR_B, WR_GO, RD_ST, WT_ST, RD_LO, WT_LO, RD_HI, WT_HI, DONE
  } state_t;

  state_t        state, state_n;
  logic [SZ-1:0] a_q, b_q;
  logic [CW-1:0] poll_cnt;
  logic          job_take;
  logic          poll_miss;
  logic          poll_expired;

  assign job_take     = (state == IDLE) && job_valid && job_ready;
  assign poll_miss    = (state == WT_ST) && avm_readdatavalid && !avm_readdata[0];
  assign poll_expired = poll_miss && (poll_cnt == LAST_POLL);
  assign res_valid    = (state == DONE);

  // Command outputs decode straight from the state, so they stay put while stalled.
  always_comb begin
    state_n       = state;
    avm_address   = '0;
    avm_read      = 1'b0;
    avm_write     = 1'b0;
    avm_writedata = '0;
    case (state)
      IDLE:  if (job_take) state_n = WR_A;
      WR_A: begin
        avm_write     = 1'b1;
        avm_address   = REG_A;
        avm_writedata = a_q;
        if (!avm_waitrequest) state_n = WR_B;
      end
      WR_B: begin
        avm_write     = 1'b1;
        avm_address   = REG_B;
        avm_writedata = b_q;
        if (!avm_waitrequest) state_n = WR_GO;
      end
      WR_GO: begin
        avm_write     = 1'b1;
        avm_address   = REG_CTRL;
        avm_writedata = SZ'(1);
        if (!avm_waitrequest) state_n = RD_ST;
      end
      RD_ST: begin
        avm_read    = 1'b1;
        avm_address = REG_STATUS;
        if (!avm_waitrequest) state_n = WT_ST;
      end
      WT_ST: begin
        if (avm_readdatavalid) begin
          if (avm_readdata[0]) state_n = RD_LO;
          else if (poll_expired) state_n = DONE;
          else state_n = RD_ST;
        end
      end
      RD_LO: begin
        avm_read    = 1'b1;
        avm_address = REG_RES_LO;
        if (!avm_waitrequest) state_n = WT_LO;
      end
      WT_LO: if (avm_readdatavalid) state_n = RD_HI;
      RD_HI: begin
        avm_read    = 1'b1;
        avm_address = REG_RES_HI;
        if (!avm_waitrequest) state_n = WT_HI;
      end
      WT_HI: if (avm_readdatavalid) state_n = DONE;
      DONE:  if (res_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      state       <= IDLE;
      job_ready   <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      poll_cnt    <= '0;
      res_data    <= '0;
      res_timeout <= 1'b0;
    end else begin
      state     <= state_n;
      // Registered so it is low through reset and rises the cycle after a result handoff.
      job_ready <= (state_n == IDLE);
      if (job_take) begin
        a_q      <= job_a;
        b_q      <= job_b;
        poll_cnt <= '0;
      end
      if (poll_miss) poll_cnt <= poll_cnt + 1'b1;
      if (poll_expired) begin
        res_timeout <= 1'b1;
        res_data    <= '0;
      end
      if ((state == WT_LO) && avm_readdatavalid) res_data[SZ-1:0] <= avm_readdata;
      if ((state == WT_HI) && avm_readdatavalid) res_data[2*SZ-1:SZ] <= avm_readdata;
      if ((state == DONE) && res_ready) res_timeout <= 1'b0;
    end
  end

endmodule

// File: tb/tb_avalon_mm_mult_host.sv
`timescale 1ns/1ps
// Directed bench for avalon_mm_mult_host: a default instance and a POLL_LIMIT=4 instance share one slave model.
module tb_avalon_mm_mult_host;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sel = 1'b0;
  logic job_valid = 1'b0;
  logic res_ready = 1'b0;
  logic [31:0] job_a = '0;
  logic [31:0] job_b = '0;

  always #5 clk = ~clk;

  // Per-instance wires
  logic        jv0, jv1, jr0, jr1, rv0, rv1, rr0, rr1, rto0, rto1;
  logic [63:0] rdat0, rdat1;
  logic [3:0]  addr0, addr1;
  logic        rd0, rd1, wr0, wr1, wt0, wt1, rdv0, rdv1;
  logic [31:0] wd0, wd1;

  // Selected-instance view
  logic        jr_m, rv_m, rto_m, m_read, m_write, m_cmd;
  logic [63:0] rdat_m;
  logic [3:0]  m_addr;
  logic [31:0] m_wdata;

  // Slave model configuration (written only by the stimulus process)
  int          wait_cfg = 0;
  int          rd_lat = 1;
  int          st_zeros = 0;
  bit          st_never = 1'b0;
  logic [31:0] res_lo = '0;
  logic [31:0] res_hi = '0;
  int          base_wr = 0;
  int          base_rd[16];
  int          base_unst = 0;

  // Slave model state (written only by the model process)
  logic        s_wait, s_rdv;
  logic [31:0] s_rdata = '0;
  int          stall_cnt = 0;
  int          pend = 0;
  int          rd_cnt[16];
  int          n_wr = 0;
  logic [3:0]  wr_addr[64];
  logic [31:0] wr_dat[64];
  int          unstable = 0;
  bit          chk_stable = 1'b0;
  logic [3:0]  snap_addr = '0;
  logic        snap_rd = 1'b0;
  logic        snap_wr = 1'b0;
  logic [31:0] snap_wd = '0;

  int errors = 0;
  int checks = 0;

  assign jv0 = job_valid && !sel;
  assign jv1 = job_valid && sel;
  assign rr0 = res_ready && !sel;
  assign rr1 = res_ready && sel;
  assign jr_m    = sel ? jr1 : jr0;
  assign rv_m    = sel ? rv1 : rv0;
  assign rto_m   = sel ? rto1 : rto0;
  assign rdat_m  = sel ? rdat1 : rdat0;
  assign m_addr  = sel ? addr1 : addr0;
  assign m_read  = sel ? rd1 : rd0;
  assign m_write = sel ? wr1 : wr0;
  assign m_wdata = sel ? wd1 : wd0;
  assign m_cmd   = m_read || m_write;
  assign s_wait  = m_cmd && (stall_cnt < wait_cfg);
  assign s_rdv   = (pend == 1);
  assign wt0  = sel ? 1'b1 : s_wait;
  assign wt1  = sel ? s_wait : 1'b1;
  assign rdv0 = s_rdv && !sel;
  assign rdv1 = s_rdv && sel;

  avalon_mm_mult_host dut0 (
    .clk(clk), ._rst(rst_n),
    .job_valid(jv0), .job_ready(jr0), .job_a(job_a), .job_b(job_b),
    .res_valid(rv0), .res_ready(rr0), .res_data(rdat0), .res_timeout(rto0),
    .avm_address(addr0), .avm_read(rd0), .avm_write(wr0), .avm_writedata(wd0),
    .avm_readdata(s_rdata), .avm_waitrequest(wt0), .avm_readdatavalid(rdv0)
  );

  avalon_mm_mult_host #(.POLL_LIMIT(4)) dut1 (
    .clk(clk), ._rst(rst_n),
    .job_valid(jv1), .job_ready(jr1), .job_a(job_a), .job_b(job_b),
    .res_valid(rv1), .res_ready(rr1), .res_data(rdat1), .res_timeout(rto1),
    .avm_address(addr1), .avm_read(rd1), .avm_write(wr1), .avm_writedata(wd1),
    .avm_readdata(s_rdata), .avm_waitrequest(wt1), .avm_readdatavalid(rdv1)
  );

  initial begin
    for (int i = 0; i < 16; i++) begin
      rd_cnt[i]  = 0;
      base_rd[i] = 0;
    end
  end

  // Slave model: logs accepted commands, answers reads after rd_lat cycles, flags commands that move under stall.
  always @(posedge clk) begin
    if (chk_stable && (m_addr !== snap_addr || m_read !== snap_rd ||
                       m_write !== snap_wr || m_wdata !== snap_wd))
      unstable <= unstable + 1;
    chk_stable <= m_cmd && s_wait;
    snap_addr  <= m_addr;
    snap_rd    <= m_read;
    snap_wr    <= m_write;
    snap_wd    <= m_wdata;
    if (m_cmd && s_wait) stall_cnt <= stall_cnt + 1;
    else stall_cnt <= 0;
    if (pend != 0) pend <= pend - 1;
    if (m_cmd && !s_wait) begin
      if (m_write) begin
        if (n_wr < 64) begin
          wr_addr[n_wr] <= m_addr;
          wr_dat[n_wr]  <= m_wdata;
        end
        n_wr <= n_wr + 1;
      end else begin
        rd_cnt[m_addr] <= rd_cnt[m_addr] + 1;
        pend <= rd_lat;
        case (m_addr)
          4'd3:    s_rdata <= (!st_never && (rd_cnt[3] - base_rd[3] >= st_zeros)) ? 32'd1 : 32'd0;
          4'd4:    s_rdata <= res_lo;
          4'd5:    s_rdata <= res_hi;
          default: s_rdata <= 32'hDEAD_BEEF;
        endcase
      end
    end
  end

  function automatic logic [107:0] wlog();
    return {wr_addr[base_wr],     wr_dat[base_wr],
            wr_addr[base_wr + 1], wr_dat[base_wr + 1],
            wr_addr[base_wr + 2], wr_dat[base_wr + 2]};
  endfunction

  task automatic cfg(input int w, input int lat, input int zeros, input bit never,
                     input logic [31:0] lo, input logic [31:0] hi);
    wait_cfg = w;
    rd_lat   = lat;
    st_zeros = zeros;
    st_never = never;
    res_lo   = lo;
    res_hi   = hi;
  endtask

  task automatic snap_log();
    base_wr = n_wr;
    for (int i = 0; i < 16; i++) base_rd[i] = rd_cnt[i];
    base_unst = unstable;
  endtask

  // Offers one job, then counts edges from the accept edge until res_valid (400 means never).
  task automatic do_job(input logic [31:0] a, input logic [31:0] b, output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    job_valid = 1'b1;
    job_a = a;
    job_b = b;
    while (!jr_m && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1;
    job_valid = 1'b0;
    job_a = ~a;
    job_b = ~b;
    lat = 0;
    while (!rv_m && lat < 400) begin
      @(posedge clk);
      lat++;
      #1;
    end
  endtask

  task automatic take_result();
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({jr0, rv0, rto0, rd0, wr0} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 00000", {jr0, rv0, rto0, rd0, wr0});
    end
    checks++;
    if ({addr0, wd0, rdat0} !== 100'd0) begin
      errors++;
      $display("FAIL reset_data: got %h expected 0", {addr0, wd0, rdat0});
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (jr0 !== 1'b1) begin
      errors++;
      $display("FAIL reset_job_ready: got %b expected 1", jr0);
    end
  endtask

  task automatic test_basic();
    int lat;
    cfg(0, 1, 0, 1'b0, 32'd15, 32'd0);
    snap_log();
    do_job(32'd3, 32'd5, lat);
    checks++;
    if (lat !== 9) begin
      errors++;
      $display("FAIL basic_latency: got %0d expected 9", lat);
    end
    checks++;
    if (n_wr - base_wr !== 3 || wlog() !== {4'd0, 32'd3, 4'd1, 32'd5, 4'd2, 32'd1}) begin
      errors++;
      $display("FAIL basic_writes: got n=%0d log=%h expected n=3", n_wr - base_wr, wlog());
    end
    checks++;
    if ({rto_m, rdat_m} !== {1'b0, 64'd15}) begin
      errors++;
      $display("FAIL basic_result: got to=%b data=%h expected to=0 data=f", rto_m, rdat_m);
    end
    checks++;
    if ({rd_cnt[3] - base_rd[3], rd_cnt[4] - base_rd[4], rd_cnt[5] - base_rd[5]} !== {32'd1, 32'd1, 32'd1}) begin
      errors++;
      $display("FAIL basic_reads: got st=%0d lo=%0d hi=%0d expected 1 1 1",
               rd_cnt[3] - base_rd[3], rd_cnt[4] - base_rd[4], rd_cnt[5] - base_rd[5]);
    end
    take_result();
    checks++;
    if ({rv_m, jr_m, rdat_m} !== {1'b0, 1'b1, 64'd15}) begin
      errors++;
      $display("FAIL basic_handoff: got rv=%b jr=%b data=%h expected rv=0 jr=1 data=f", rv_m, jr_m, rdat_m);
    end
  endtask

  task automatic test_max_operands();
    int lat;
    cfg(0, 1, 0, 1'b0, 32'h0000_0001, 32'hFFFF_FFFE);
    snap_log();
    do_job(32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    checks++;
    if (wlog() !== {4'd0, 32'hFFFF_FFFF, 4'd1, 32'hFFFF_FFFF, 4'd2, 32'd1}) begin
      errors++;
      $display("FAIL max_writes: got %h", wlog());
    end
    checks++;
    if (rdat_m !== 64'hFFFF_FFFE_0000_0001) begin
      errors++;
      $display("FAIL max_result: got %h expected fffffffe00000001", rdat_m);
    end
    take_result();
  endtask

  task automatic test_stall();
    int lat;
    cfg(3, 4, 0, 1'b0, 32'd15, 32'd0);
    snap_log();
    do_job(32'd3, 32'd5, lat);
    checks++;
    if (unstable - base_unst !== 0) begin
      errors++;
      $display("FAIL stall_stable: got %0d changes under waitrequest expected 0", unstable - base_unst);
    end
    checks++;
    if (n_wr - base_wr !== 3 || wlog() !== {4'd0, 32'd3, 4'd1, 32'd5, 4'd2, 32'd1}) begin
      errors++;
      $display("FAIL stall_writes: got n=%0d log=%h expected n=3", n_wr - base_wr, wlog());
    end
    checks++;
    if ({rd_cnt[3] - base_rd[3], rd_cnt[4] - base_rd[4], rd_cnt[5] - base_rd[5]} !== {32'd1, 32'd1, 32'd1}) begin
      errors++;
      $display("FAIL stall_reads: got st=%0d lo=%0d hi=%0d expected 1 1 1",
               rd_cnt[3] - base_rd[3], rd_cnt[4] - base_rd[4], rd_cnt[5] - base_rd[5]);
    end
    // Six commands each stall 3 cycles and three reads wait 3 extra cycles: 9 + 18 + 9.
    checks++;
    if (lat !== 36) begin
      errors++;
      $display("FAIL stall_latency: got %0d expected 36", lat);
    end
    checks++;
    if (rdat_m !== 64'd15) begin
      errors++;
      $display("FAIL stall_result: got %h expected f", rdat_m);
    end
    take_result();
  endtask

  task automatic test_poll();
    int lat;
    cfg(0, 1, 3, 1'b0, 32'd15, 32'd0);
    snap_log();
    do_job(32'd3, 32'd5, lat);
    checks++;
    if ({rd_cnt[3] - base_rd[3], rd_cnt[4] - base_rd[4]} !== {32'd4, 32'd1}) begin
      errors++;
      $display("FAIL poll_reads: got st=%0d lo=%0d expected 4 1", rd_cnt[3] - base_rd[3], rd_cnt[4] - base_rd[4]);
    end
    checks++;
    if ({lat, rto_m, rdat_m} !== {32'd15, 1'b0, 64'd15}) begin
      errors++;
      $display("FAIL poll_result: got lat=%0d to=%b data=%h expected 15 0 f", lat, rto_m, rdat_m);
    end
    take_result();
  endtask

  task automatic test_timeout();
    int lat;
    sel = 1'b1;
    cfg(0, 1, 0, 1'b0, 32'd15, 32'd0);
    do_job(32'd3, 32'd5, lat);
    checks++;
    if (rdat_m !== 64'd15) begin
      errors++;
      $display("FAIL timeout_prejob: got %h expected f", rdat_m);
    end
    take_result();
    cfg(0, 1, 0, 1'b1, 32'd15, 32'd0);
    snap_log();
    do_job(32'd6, 32'd7, lat);
    checks++;
    if ({rd_cnt[3] - base_rd[3], rd_cnt[4] - base_rd[4] + rd_cnt[5] - base_rd[5]} !== {32'd4, 32'd0}) begin
      errors++;
      $display("FAIL timeout_reads: got st=%0d res=%0d expected 4 0",
               rd_cnt[3] - base_rd[3], rd_cnt[4] - base_rd[4] + rd_cnt[5] - base_rd[5]);
    end
    checks++;
    if ({lat, rv_m, rto_m, rdat_m} !== {32'd11, 1'b1, 1'b1, 64'd0}) begin
      errors++;
      $display("FAIL timeout_result: got lat=%0d rv=%b to=%b data=%h expected 11 1 1 0", lat, rv_m, rto_m, rdat_m);
    end
    take_result();
    checks++;
    if ({rv_m, rto_m, jr_m} !== 3'b001) begin
      errors++;
      $display("FAIL timeout_clear: got rv/to/jr=%b expected 001", {rv_m, rto_m, jr_m});
    end
    sel = 1'b0;
  endtask

  task automatic test_backpressure();
    int lat;
    cfg(0, 1, 0, 1'b0, 32'd15, 32'd0);
    do_job(32'd3, 32'd5, lat);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if ({rv_m, jr_m, rto_m, m_read, m_write, rdat_m} !== {5'b10000, 64'd15}) begin
        errors++;
        $display("FAIL backpressure_hold: cycle %0d got rv/jr/to/rd/wr=%b data=%h expected 10000 f",
                 c, {rv_m, jr_m, rto_m, m_read, m_write}, rdat_m);
      end
    end
    take_result();
  endtask

  task automatic test_reset_mid();
    int lat;
    int guard;
    cfg(0, 4, 0, 1'b1, 32'd15, 32'd0);
    snap_log();
    @(negedge clk);
    job_valid = 1'b1;
    job_a = 32'd7;
    job_b = 32'd9;
    @(posedge clk);
    #1;
    job_valid = 1'b0;
    guard = 0;
    while (rd_cnt[3] == base_rd[3] && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (guard >= 100) begin
      errors++;
      $display("FAIL reset_mid_reach: got no status read within %0d cycles expected one", guard);
    end
    // Status read is in flight with readdatavalid still pending.
    rst_n = 1'b0;
    #1;
    checks++;
    if ({jr0, rv0, rto0, rd0, wr0, addr0, wd0, rdat0} !== 105'd0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got %h expected 0", {jr0, rv0, rto0, rd0, wr0, addr0, wd0, rdat0});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if ({jr0, rv0, rd0, wr0} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_mid_idle: got jr/rv/rd/wr=%b expected 1000", {jr0, rv0, rd0, wr0});
    end
    cfg(0, 1, 0, 1'b0, 32'd15, 32'd0);
    snap_log();
    do_job(32'd3, 32'd5, lat);
    checks++;
    if ({lat, rto_m, rdat_m} !== {32'd9, 1'b0, 64'd15} || wlog() !== {4'd0, 32'd3, 4'd1, 32'd5, 4'd2, 32'd1}) begin
      errors++;
      $display("FAIL reset_mid_nextjob: got lat=%0d to=%b data=%h log=%h expected 9 0 f", lat, rto_m, rdat_m, wlog());
    end
    take_result();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max_operands();
    test_stall();
    test_poll();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion by 500us expected finish");
    $fatal(1);
  end

endmodule
